// File: rtl/job_dispatcher.sv
// Batches host decompression jobs into io_control: one job per slot, pads partial batches,
// launches, waits for io_control to finish, then returns one completion per real job.
module job_dispatcher #(
    parameter int unsigned NUM_DECOMPRESSOR = 2,
    parameter int unsigned TIMEOUT          = 256,
    parameter logic [63:0] DUMMY_SRC        = 64'h0,
    parameter logic [63:0] DUMMY_DES        = 64'h40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [63:0] job_src_addr,
    input  logic [63:0] job_des_addr,
    input  logic [34:0] job_comp_len,
    input  logic [31:0] job_decomp_len,
    input  logic [15:0] job_tag,
    input  logic        flush,
    output logic [63:0] src_addr,
    output logic [63:0] des_addr,
    output logic [34:0] compression_length,
    output logic [31:0] decompression_length,
    output logic [15:0] job_id_o,
    output logic        job_valid_o,
    output logic        start_o,
    input  logic        io_idle,
    input  logic        io_done,
    output logic        cpl_valid,
    input  logic        cpl_ready,
    output logic [15:0] cpl_tag,
    output logic        busy,
    output logic [31:0] batch_count
);
    localparam int unsigned   N          = NUM_DECOMPRESSOR;
    localparam int unsigned   IW         = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned   TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [6:0]    SLOT_N     = 7'(N);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {COLLECT, PAD, LAUNCH, START, RUN, REPORT} state_t;

    state_t          state, state_d;
    logic [6:0]      slot;
    logic [IW-1:0]   slot_idx;
    logic [TW-1:0]   timer;
    logic [N-1:0]    dummy;
    logic [15:0]     tag_mem [N];
    logic            seen_busy;
    logic            accept, timeout_hit, pad_req;
    logic            load_real, load_pad;
    logic            rpt_hit, rpt_more;
    logic [IW-1:0]   rpt_idx;

    assign slot_idx    = slot[IW-1:0];
    assign job_ready   = (state == COLLECT) && (slot < SLOT_N);
    assign accept      = job_valid & job_ready;
    assign timeout_hit = (TIMEOUT != 0) && (slot != 7'd0) && (timer == TIMER_LAST);
    assign pad_req     = flush | timeout_hit;
    assign busy        = (state != COLLECT) || (slot != 7'd0);
    assign cpl_tag     = cpl_valid ? tag_mem[rpt_idx] : 16'h0;

    // Find the next real slot at or above the walk pointer, and whether another follows it,
    // so dummy slots cost no cycles and the last handshake returns straight to COLLECT.
    always_comb begin
        rpt_hit  = 1'b0;
        rpt_more = 1'b0;
        rpt_idx  = '0;
        for (int i = 0; i < int'(N); i++) begin
            if ((7'(i) >= slot) && !dummy[i]) begin
                if (rpt_hit) begin
                    rpt_more = 1'b1;
                end else begin
                    rpt_hit = 1'b1;
                    rpt_idx = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_d;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state;
        load_real = 1'b0;
        load_pad  = 1'b0;
        start_o   = 1'b0;
        cpl_valid = 1'b0;
        case (state)
            COLLECT: begin
                if (slot == SLOT_N) begin
                    state_d = LAUNCH;
                end else if (accept) begin
                    load_real = 1'b1;
                    if (pad_req) state_d = PAD;
                end else if (pad_req && (slot != 7'd0)) begin
                    load_pad = 1'b1;
                    state_d  = PAD;
                end
            end
            PAD: begin
                if (slot == SLOT_N) state_d = LAUNCH;
                else                load_pad = 1'b1;
            end
            LAUNCH:  state_d = START;
            START: begin
                start_o = 1'b1;
                state_d = RUN;
            end
            // A done seen before io_control has gone busy belongs to the previous batch.
            RUN: if (seen_busy && io_idle && io_done) state_d = REPORT;
            REPORT: begin
                cpl_valid = rpt_hit;
                if (!rpt_hit || (cpl_ready && !rpt_more)) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot                 <= '0;
            timer                <= '0;
            dummy                <= '0;
            seen_busy            <= 1'b0;
            batch_count          <= '0;
            job_valid_o          <= 1'b0;
            job_id_o             <= '0;
            src_addr             <= '0;
            des_addr             <= '0;
            compression_length   <= '0;
            decompression_length <= '0;
        end else begin
            job_valid_o <= load_real | load_pad;
            if (load_real || load_pad) begin
                job_id_o        <= 16'(slot);
                dummy[slot_idx] <= load_pad;
                slot            <= slot + 7'd1;
            end
            if (load_real) begin
                src_addr             <= job_src_addr;
                des_addr             <= job_des_addr;
                compression_length   <= job_comp_len;
                decompression_length <= job_decomp_len;
            end else if (load_pad) begin
                src_addr             <= DUMMY_SRC;
                des_addr             <= DUMMY_DES;
                compression_length   <= 35'd64;
                decompression_length <= 32'd64;
            end

            if (state == COLLECT) begin
                if (accept && (slot == 7'd0))                    timer <= '0;
                else if ((slot != 7'd0) && (timer != TIMER_LAST)) timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end

            if (state == START) begin
                seen_busy   <= 1'b0;
                batch_count <= batch_count + 32'd1;
            end else if ((state == RUN) && !io_idle) begin
                seen_busy <= 1'b1;
            end

            if ((state == RUN) && (state_d == REPORT)) slot <= '0;
            if (state == REPORT) begin
                if (!rpt_hit)       slot <= '0;
                else if (cpl_ready) slot <= rpt_more ? (7'(rpt_idx) + 7'd1) : 7'd0;
            end
        end
    end

    // NOTE: the tag store has no reset; each entry is written before REPORT can read it.
    always_ff @(posedge clk) begin
        if (load_real) tag_mem[slot_idx] <= job_tag;
    end

endmodule

// File: tb/tb_job_dispatcher.sv
// Directed bench for job_dispatcher (2 slots, 8-cycle timeout): batching, padding, timeout,
// completion back-pressure, stale done filtering and asynchronous reset in RUN.
module tb_job_dispatcher;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    logic [63:0] job_src_addr;
    logic [63:0] job_des_addr;
    logic [34:0] job_comp_len;
    logic [31:0] job_decomp_len;
    logic [15:0] job_tag;
    logic        flush;
    logic [63:0] src_addr;
    logic [63:0] des_addr;
    logic [34:0] compression_length;
    logic [31:0] decompression_length;
    logic [15:0] job_id_o;
    logic        job_valid_o;
    logic        start_o;
    logic        io_idle;
    logic        io_done;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [15:0] cpl_tag;
    logic        busy;
    logic [31:0] batch_count;

    int n_assert = 0;
    int n_fail   = 0;

    job_dispatcher #(.NUM_DECOMPRESSOR(2), .TIMEOUT(8)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .job_valid            (job_valid),
        .job_ready            (job_ready),
        .job_src_addr         (job_src_addr),
        .job_des_addr         (job_des_addr),
        .job_comp_len         (job_comp_len),
        .job_decomp_len       (job_decomp_len),
        .job_tag              (job_tag),
        .flush                (flush),
        .src_addr             (src_addr),
        .des_addr             (des_addr),
        .compression_length   (compression_length),
        .decompression_length (decompression_length),
        .job_id_o             (job_id_o),
        .job_valid_o          (job_valid_o),
        .start_o              (start_o),
        .io_idle              (io_idle),
        .io_done              (io_done),
        .cpl_valid            (cpl_valid),
        .cpl_ready            (cpl_ready),
        .cpl_tag              (cpl_tag),
        .busy                 (busy),
        .batch_count          (batch_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_job(input logic [63:0] s, input logic [63:0] d, input logic [34:0] cl,
                           input logic [31:0] dl, input logic [15:0] t);
        job_src_addr   = s;
        job_des_addr   = d;
        job_comp_len   = cl;
        job_decomp_len = dl;
        job_tag        = t;
    endtask

    initial begin
        rst_n = 1'b0; job_valid = 1'b0; flush = 1'b0;
        io_idle = 1'b1; io_done = 1'b0; cpl_ready = 1'b0;
        set_job(64'h0, 64'h0, 35'd1, 32'd1, 16'h0);
        #3;
        check("rst_job_ready", job_ready, 1);
        check("rst_job_valid_o", job_valid_o, 0);
        check("rst_start_o", start_o, 0);
        check("rst_cpl_valid", cpl_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_batch_count", batch_count, 0);
        #4 rst_n = 1'b1;
        tick;

        // Full batch of two real jobs
        set_job(64'h1000, 64'h2000, 35'd100, 32'd200, 16'hA1);
        job_valid = 1'b1;
        tick;
        check("t1_beat0_valid", job_valid_o, 1);
        check("t1_beat0_id", job_id_o, 0);
        check("t1_beat0_src", src_addr, 64'h1000);
        check("t1_beat0_des", des_addr, 64'h2000);
        check("t1_beat0_clen", compression_length, 100);
        check("t1_beat0_dlen", decompression_length, 200);
        check("t1_busy", busy, 1);
        set_job(64'h1100, 64'h2100, 35'd300, 32'd400, 16'hA2);
        tick;
        check("t1_beat1_valid", job_valid_o, 1);
        check("t1_beat1_id", job_id_o, 1);
        check("t1_beat1_src", src_addr, 64'h1100);
        check("t1_beat1_clen", compression_length, 300);
        check("t1_full_ready", job_ready, 0);
        check("t1_no_early_start", start_o, 0);
        job_valid = 1'b0;
        tick;
        check("t1_gap_valid", job_valid_o, 0);
        check("t1_gap_start", start_o, 0);
        tick;
        check("t1_start", start_o, 1);
        check("t1_start_no_beat", job_valid_o, 0);
        check("t1_count_before", batch_count, 0);
        tick;
        check("t1_start_pulse_end", start_o, 0);
        check("t1_batch_count", batch_count, 1);
        io_idle = 1'b0;
        tick;
        io_idle = 1'b1; io_done = 1'b1;
        check("t1_run_no_cpl", cpl_valid, 0);
        tick;
        io_done = 1'b0;
        check("t1_cpl0_valid", cpl_valid, 1);
        check("t1_cpl0_tag", cpl_tag, 16'hA1);
        cpl_ready = 1'b1;
        tick;
        check("t1_cpl1_valid", cpl_valid, 1);
        check("t1_cpl1_tag", cpl_tag, 16'hA2);
        tick;
        check("t1_done_cpl", cpl_valid, 0);
        check("t1_done_ready", job_ready, 1);
        check("t1_done_busy", busy, 0);
        cpl_ready = 1'b0;

        // One job then flush: pad the second slot
        set_job(64'h3000, 64'h4000, 35'd10, 32'd20, 16'h0005);
        job_valid = 1'b1;
        tick;
        check("t2_beat0_id", job_id_o, 0);
        job_valid = 1'b0; flush = 1'b1;
        tick;
        flush = 1'b0;
        check("t2_pad_valid", job_valid_o, 1);
        check("t2_pad_id", job_id_o, 1);
        check("t2_pad_src", src_addr, 64'h0);
        check("t2_pad_des", des_addr, 64'h40);
        check("t2_pad_clen", compression_length, 64);
        check("t2_pad_dlen", decompression_length, 64);
        check("t2_pad_ready", job_ready, 0);
        tick;
        check("t2_gap_valid", job_valid_o, 0);
        tick;
        check("t2_start", start_o, 1);
        tick;
        check("t2_batch_count", batch_count, 2);
        io_idle = 1'b0;
        tick;
        io_idle = 1'b1; io_done = 1'b1;
        tick;
        io_done = 1'b0;
        check("t2_cpl_valid", cpl_valid, 1);
        check("t2_cpl_tag", cpl_tag, 16'h0005);
        for (int i = 0; i < 20; i++) begin
            tick;
            check("t2_hold_valid", cpl_valid, 1);
            check("t2_hold_tag", cpl_tag, 16'h0005);
            check("t2_hold_ready", job_ready, 0);
        end
        cpl_ready = 1'b1;
        tick;
        check("t2_only_one_cpl", cpl_valid, 0);
        check("t2_back_ready", job_ready, 1);
        cpl_ready = 1'b0;

        // Flush with an empty batch is ignored
        flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t3_no_beat", job_valid_o, 0);
            check("t3_no_start", start_o, 0);
            check("t3_not_busy", busy, 0);
        end
        flush = 1'b0;

        // Timeout pads exactly 8 cycles after the accept; then a stale done at START
        set_job(64'h5000, 64'h6000, 35'd1, 32'd1, 16'h0077);
        job_valid = 1'b1;
        tick;
        job_valid = 1'b0;
        check("t4_beat0_valid", job_valid_o, 1);
        for (int k = 1; k < 8; k++) begin
            tick;
            check("t4_no_early_pad", job_valid_o, 0);
        end
        tick;
        check("t4_pad_valid", job_valid_o, 1);
        check("t4_pad_id", job_id_o, 1);
        check("t4_pad_src", src_addr, 64'h0);
        io_done = 1'b1;
        tick;
        tick;
        check("t4_start", start_o, 1);
        tick;
        check("t4_batch_count", batch_count, 3);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("t4_stale_done_cpl", cpl_valid, 0);
            check("t4_stale_done_busy", busy, 1);
        end
        io_idle = 1'b0;
        tick;
        check("t4_busy_phase_cpl", cpl_valid, 0);
        io_idle = 1'b1;
        tick;
        check("t4_cpl_valid", cpl_valid, 1);
        check("t4_cpl_tag", cpl_tag, 16'h0077);
        cpl_ready = 1'b1; io_done = 1'b0;
        tick;
        check("t4_done_cpl", cpl_valid, 0);
        check("t4_done_ready", job_ready, 1);
        cpl_ready = 1'b0;

        // Reset while in RUN
        set_job(64'h7000, 64'h7100, 35'd5, 32'd6, 16'h0011);
        job_valid = 1'b1;
        tick;
        set_job(64'h7200, 64'h7300, 35'd7, 32'd8, 16'h0022);
        tick;
        job_valid = 1'b0;
        tick;
        tick;
        tick;
        check("t5_batch_count", batch_count, 4);
        io_idle = 1'b0;
        tick;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_job_ready", job_ready, 1);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_batch_count", batch_count, 0);
        check("t5_rst_job_id", job_id_o, 0);
        check("t5_rst_src", src_addr, 0);
        check("t5_rst_start", start_o, 0);
        check("t5_rst_cpl_valid", cpl_valid, 0);
        io_idle = 1'b1;
        #2 rst_n = 1'b1;
        tick;
        set_job(64'h8000, 64'h9000, 35'd5, 32'd6, 16'h0033);
        job_valid = 1'b1;
        tick;
        check("t5_new_beat_valid", job_valid_o, 1);
        check("t5_new_beat_id", job_id_o, 0);
        job_valid = 1'b0; flush = 1'b1;
        tick;
        flush = 1'b0;
        check("t5_pad_id", job_id_o, 1);
        tick;
        tick;
        check("t5_start", start_o, 1);
        tick;
        check("t5_batch_restart", batch_count, 1);
        io_idle = 1'b0;
        tick;
        io_idle = 1'b1; io_done = 1'b1;
        tick;
        io_done = 1'b0;
        check("t5_cpl_valid", cpl_valid, 1);
        check("t5_cpl_tag", cpl_tag, 16'h0033);
        cpl_ready = 1'b1;
        tick;
        check("t5_done_cpl", cpl_valid, 0);
        cpl_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
